// File: rtl/axi_10g_ethernet_0_pkg.sv
// -----------------------------------------------------------------------------
// axi_10g_ethernet_0_pkg
// Constants shared by the ICMP echo receiver and the ICMP reply generator.
//   - Ethernet / IPv4 / ICMP header values recognised for an echo request.
//   - Beat indices (64-bit beats, byte 8k+n on lane n) of the header fields.
//   - Receiver FSM state type.
// -----------------------------------------------------------------------------
package axi_10g_ethernet_0_pkg;

  // Header values of an IPv4 ICMP echo request with 32 bytes of payload
  localparam logic [15:0] ETHERTYPE_IPV4     = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL         = 8'h45;
  localparam logic [15:0] IP_TOTAL_LEN_ECHO  = 16'd60;
  localparam logic [7:0]  IP_PROTO_ICMP      = 8'd1;
  localparam logic [7:0]  ICMP_TYPE_ECHO_REQ = 8'd8;
  localparam logic [7:0]  ICMP_CODE_ECHO     = 8'd0;

  // Echo payload: frame bytes 42..73
  localparam int ICMP_DATA_BYTES      = 32;
  localparam int ICMP_DATA_FIRST_BYTE = 42;

  // Beat indices of the header fields
  localparam logic [3:0] BEAT_MAC_DST  = 4'd0;  // dst MAC, src MAC bytes 6..7
  localparam logic [3:0] BEAT_MAC_SRC  = 4'd1;  // src MAC 8..11, ethertype, ver/IHL
  localparam logic [3:0] BEAT_IP_LEN   = 4'd2;  // total length, protocol
  localparam logic [3:0] BEAT_IP_SRC   = 4'd3;  // src IP, dst IP bytes 30..31
  localparam logic [3:0] BEAT_ICMP_HDR = 4'd4;  // dst IP 32..33, type, code, identifier
  localparam logic [3:0] BEAT_ICMP_SEQ = 4'd5;  // sequence number, payload start
  localparam logic [3:0] BEAT_LAST     = 4'd9;  // payload bytes 72..73 on lanes 0..1
  localparam logic [3:0] BEAT_CNT_SAT  = 4'd10; // any beat beyond the echo frame

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PARSE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_BUSY  = 2'd3
  } icmp_rx_state_t;

endpackage

// File: rtl/axi_10g_ethernet_0_icmp_receiver.sv
// -----------------------------------------------------------------------------
// axi_10g_ethernet_0_icmp_receiver
// Watches the 64-bit AXI-Stream receive path for ICMP echo requests addressed
// to this board, captures the fields needed to build a reply and hands them to
// the reply generator with a one-cycle tx_icmp_en pulse.
//
// Ports
//   aclk, areset             clock, asynchronous active-high reset
//   rx_axis_tdata/tkeep      receive beat, byte 8k+n on lane n
//   rx_axis_tvalid/tlast     beat valid (no backpressure), last beat of frame
//   rx_axis_tuser            frame good, meaningful on the tlast beat
//   tx_icmp_en               pulse, cycle after the tlast beat of an accepted frame
//   icmp_src_mac/ip          requester MAC / IPv4 address
//   icmp_src_identifier      ICMP identifier
//   icmp_src_sequence_number ICMP sequence number
//   icmp_src_data            32-byte echo payload, first byte at [255:248]
//   icmp_reply_done          reply generator finished, releases BUSY
// -----------------------------------------------------------------------------
module axi_10g_ethernet_0_icmp_receiver
  import axi_10g_ethernet_0_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC = 48'h02_00_c0_a8_0a_0a,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd2, 8'd20}
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic [63:0]  rx_axis_tdata,
  input  logic [7:0]   rx_axis_tkeep,
  input  logic         rx_axis_tvalid,
  input  logic         rx_axis_tlast,
  input  logic         rx_axis_tuser,
  output logic         tx_icmp_en,
  output logic [47:0]  icmp_src_mac,
  output logic [31:0]  icmp_src_ip,
  output logic [15:0]  icmp_src_identifier,
  output logic [15:0]  icmp_src_sequence_number,
  output logic [255:0] icmp_src_data,
  input  logic         icmp_reply_done
);

  icmp_rx_state_t r_state, w_state_next;

  logic [3:0]   r_beat_cnt;
  logic         r_err;
  logic         r_resync;
  logic         r_in_frame;

  // Shadow registers, filled while the frame streams in
  logic [47:0]  r_mac_sh,  w_mac_sh_next;
  logic [31:0]  r_ip_sh,   w_ip_sh_next;
  logic [15:0]  r_id_sh,   w_id_sh_next;
  logic [15:0]  r_seq_sh,  w_seq_sh_next;
  logic [255:0] r_data_sh, w_data_sh_next;

  // Output registers, only loaded on acceptance
  logic         r_tx_en;
  logic [47:0]  r_mac_out;
  logic [31:0]  r_ip_out;
  logic [15:0]  r_id_out;
  logic [15:0]  r_seq_out;
  logic [255:0] r_data_out;

  logic [7:0]   w_b [8];
  logic         w_beat_vld;
  logic [3:0]   w_beat_idx;
  logic         w_err_beat;
  logic         w_err_any;
  logic         w_frame_end;
  logic         w_accept;
  logic         w_in_frame_next;

  // Byte lanes of the current beat
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign w_b[gi] = rx_axis_tdata[8*gi +: 8];
    end
  endgenerate

  // A beat is parsed only as beat 0 of a synchronised frame or during PARSE;
  // BUSY and DRAIN only follow framing.
  assign w_beat_vld  = rx_axis_tvalid &&
                       (((r_state == ST_IDLE) && !r_resync) || (r_state == ST_PARSE));
  assign w_beat_idx  = (r_state == ST_IDLE) ? BEAT_MAC_DST : r_beat_cnt;
  assign w_frame_end = rx_axis_tvalid && rx_axis_tlast;
  assign w_in_frame_next = rx_axis_tvalid ? !rx_axis_tlast : r_in_frame;

  // Per-beat field checks and shadow capture
  always_comb begin
    int k;
    k              = 0;
    w_err_beat     = 1'b0;
    w_mac_sh_next  = r_mac_sh;
    w_ip_sh_next   = r_ip_sh;
    w_id_sh_next   = r_id_sh;
    w_seq_sh_next  = r_seq_sh;
    w_data_sh_next = r_data_sh;

    if (w_beat_vld) begin
      case (w_beat_idx)
        BEAT_MAC_DST: begin
          if ({w_b[0], w_b[1], w_b[2], w_b[3], w_b[4], w_b[5]} != BOARD_MAC)
            w_err_beat = 1'b1;
          w_mac_sh_next[47:32] = {w_b[6], w_b[7]};
        end
        BEAT_MAC_SRC: begin
          w_mac_sh_next[31:0] = {w_b[0], w_b[1], w_b[2], w_b[3]};
          if ({w_b[4], w_b[5]} != ETHERTYPE_IPV4) w_err_beat = 1'b1;
          if (w_b[6] != IP_VER_IHL)               w_err_beat = 1'b1;
        end
        BEAT_IP_LEN: begin
          if ({w_b[0], w_b[1]} != IP_TOTAL_LEN_ECHO) w_err_beat = 1'b1;
          if (w_b[7] != IP_PROTO_ICMP)               w_err_beat = 1'b1;
        end
        BEAT_IP_SRC: begin
          w_ip_sh_next = {w_b[2], w_b[3], w_b[4], w_b[5]};
          if ({w_b[6], w_b[7]} != BOARD_IP[31:16]) w_err_beat = 1'b1;
        end
        BEAT_ICMP_HDR: begin
          if ({w_b[0], w_b[1]} != BOARD_IP[15:0]) w_err_beat = 1'b1;
          if (w_b[2] != ICMP_TYPE_ECHO_REQ)       w_err_beat = 1'b1;
          if (w_b[3] != ICMP_CODE_ECHO)           w_err_beat = 1'b1;
          w_id_sh_next = {w_b[6], w_b[7]};
        end
        BEAT_ICMP_SEQ: begin
          w_seq_sh_next = {w_b[0], w_b[1]};
        end
        BEAT_LAST: begin
          // Payload ends on lane 1 of this beat
          if (rx_axis_tkeep[1:0] != 2'b11) w_err_beat = 1'b1;
        end
        default: ;
      endcase

      // Payload bytes 42..73 land in descending byte order from the MSB
      for (int n = 0; n < 8; n++) begin
        k = int'(w_beat_idx) * 8 + n - ICMP_DATA_FIRST_BYTE;
        if (k >= 0 && k < ICMP_DATA_BYTES)
          w_data_sh_next[255 - 8*k -: 8] = w_b[n];
      end
    end
  end

  // Error flag of the frame so far; a new frame starts with a clean slate
  assign w_err_any = ((r_state != ST_IDLE) && r_err) || w_err_beat;

  // Only a frame that reached the last payload beat can be accepted
  assign w_accept = w_frame_end && !w_err_any && rx_axis_tuser &&
                    ((r_state == ST_PARSE) || (r_state == ST_DRAIN)) &&
                    (r_beat_cnt >= BEAT_LAST);

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        // A single-beat frame is rejected on the spot
        if (w_beat_vld && !rx_axis_tlast) w_state_next = ST_PARSE;
      end
      ST_PARSE: begin
        if (rx_axis_tvalid) begin
          if (rx_axis_tlast)
            w_state_next = w_accept ? ST_BUSY : ST_IDLE;
          else if (w_err_any || (r_beat_cnt >= BEAT_LAST))
            w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_frame_end) w_state_next = w_accept ? ST_BUSY : ST_IDLE;
      end
      ST_BUSY: begin
        if (icmp_reply_done) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Beat counter, error accumulation and framing flags
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
      r_resync   <= 1'b1;
      r_in_frame <= 1'b0;
    end else begin
      r_in_frame <= w_in_frame_next;

      if (w_beat_vld || (rx_axis_tvalid && (r_state == ST_DRAIN))) begin
        if (rx_axis_tlast)
          r_beat_cnt <= '0;
        else if (w_beat_idx < BEAT_CNT_SAT)
          r_beat_cnt <= w_beat_idx + 4'd1;
      end else if (r_state == ST_BUSY) begin
        r_beat_cnt <= '0;
      end

      if (w_beat_vld) r_err <= w_err_any;

      // Leaving BUSY mid-frame must not mistake the tail for a new frame
      if ((r_state == ST_BUSY) && icmp_reply_done)
        r_resync <= w_in_frame_next;
      else if (w_frame_end)
        r_resync <= 1'b0;
    end
  end

  // Shadow and output registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_mac_sh   <= '0;
      r_ip_sh    <= '0;
      r_id_sh    <= '0;
      r_seq_sh   <= '0;
      r_data_sh  <= '0;
      r_tx_en    <= 1'b0;
      r_mac_out  <= '0;
      r_ip_out   <= '0;
      r_id_out   <= '0;
      r_seq_out  <= '0;
      r_data_out <= '0;
    end else begin
      r_mac_sh  <= w_mac_sh_next;
      r_ip_sh   <= w_ip_sh_next;
      r_id_sh   <= w_id_sh_next;
      r_seq_sh  <= w_seq_sh_next;
      r_data_sh <= w_data_sh_next;
      r_tx_en   <= w_accept;
      // Load from the next-shadow values so the last beat's payload is included
      if (w_accept) begin
        r_mac_out  <= w_mac_sh_next;
        r_ip_out   <= w_ip_sh_next;
        r_id_out   <= w_id_sh_next;
        r_seq_out  <= w_seq_sh_next;
        r_data_out <= w_data_sh_next;
      end
    end
  end

  assign tx_icmp_en               = r_tx_en;
  assign icmp_src_mac             = r_mac_out;
  assign icmp_src_ip              = r_ip_out;
  assign icmp_src_identifier      = r_id_out;
  assign icmp_src_sequence_number = r_seq_out;
  assign icmp_src_data            = r_data_out;

endmodule

// File: tb/tb_axi_10g_ethernet_0_icmp_receiver.sv
// -----------------------------------------------------------------------------
// tb_axi_10g_ethernet_0_icmp_receiver
// Directed, table-driven bench for the ICMP echo receiver: each table row is a
// frame variant plus the expected pulse; the bench keeps its own copy of the
// last accepted fields and checks the outputs against it after every frame.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_10g_ethernet_0_icmp_receiver;

  localparam logic [47:0] BOARD_MAC = 48'h02_00_c0_a8_0a_0a;
  localparam logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd2, 8'd20};
  localparam logic [31:0] IP_OTHER  = {8'd192, 8'd168, 8'd2, 8'd21};
  localparam logic [47:0] REQ_MAC   = 48'h00_11_22_33_44_55;
  localparam logic [31:0] REQ_IP    = {8'd192, 8'd168, 8'd2, 8'd100};
  localparam logic [15:0] REQ_ID    = 16'h0001;

  logic         aclk = 1'b0;
  logic         areset;
  logic [63:0]  rx_axis_tdata;
  logic [7:0]   rx_axis_tkeep;
  logic         rx_axis_tvalid;
  logic         rx_axis_tlast;
  logic         rx_axis_tuser;
  logic         tx_icmp_en;
  logic [47:0]  icmp_src_mac;
  logic [31:0]  icmp_src_ip;
  logic [15:0]  icmp_src_identifier;
  logic [15:0]  icmp_src_sequence_number;
  logic [255:0] icmp_src_data;
  logic         icmp_reply_done;

  axi_10g_ethernet_0_icmp_receiver #(
    .BOARD_MAC (BOARD_MAC),
    .BOARD_IP  (BOARD_IP)
  ) dut (
    .aclk                     (aclk),
    .areset                   (areset),
    .rx_axis_tdata            (rx_axis_tdata),
    .rx_axis_tkeep            (rx_axis_tkeep),
    .rx_axis_tvalid           (rx_axis_tvalid),
    .rx_axis_tlast            (rx_axis_tlast),
    .rx_axis_tuser            (rx_axis_tuser),
    .tx_icmp_en               (tx_icmp_en),
    .icmp_src_mac             (icmp_src_mac),
    .icmp_src_ip              (icmp_src_ip),
    .icmp_src_identifier      (icmp_src_identifier),
    .icmp_src_sequence_number (icmp_src_sequence_number),
    .icmp_src_data            (icmp_src_data),
    .icmp_reply_done          (icmp_reply_done)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    string       name;
    logic [31:0] dst_ip;
    logic [7:0]  icmp_type;
    logic [15:0] seq;
    logic        tuser;
    int          last_beat;
    logic [7:0]  keep_last;
    int          gap;
    logic        done_on_last;
    logic        done_after;
    logic        exp_pulse;
  } vec_t;

  vec_t vecs [13];

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  int exp_pulses = 0;

  logic [7:0]   fb [0:87];
  logic [47:0]  m_mac;
  logic [31:0]  m_ip;
  logic [15:0]  m_id;
  logic [15:0]  m_seq;
  logic [255:0] m_data;
  logic [255:0] payload;

  always @(posedge aclk) if (tx_icmp_en) pulse_cnt <= pulse_cnt + 1;

  function automatic vec_t mk(input string nm, input logic [31:0] dip, input logic [7:0] typ,
                              input logic [15:0] sq, input logic tu, input int lb,
                              input logic [7:0] kl, input int gp, input logic dol,
                              input logic da, input logic ep);
    vec_t v;
    v.name = nm; v.dst_ip = dip; v.icmp_type = typ; v.seq = sq; v.tuser = tu;
    v.last_beat = lb; v.keep_last = kl; v.gap = gp; v.done_on_last = dol;
    v.done_after = da; v.exp_pulse = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic build(input vec_t v);
    logic [47:0] dm;
    dm = BOARD_MAC;
    for (int i = 0; i < 88; i++) fb[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      fb[i]     = dm[47 - 8*i -: 8];
      fb[6 + i] = REQ_MAC[47 - 8*i -: 8];
    end
    fb[12] = 8'h08; fb[13] = 8'h00; fb[14] = 8'h45;
    fb[16] = 8'h00; fb[17] = 8'd60; fb[22] = 8'h40; fb[23] = 8'h01;
    for (int i = 0; i < 4; i++) begin
      fb[26 + i] = REQ_IP[31 - 8*i -: 8];
      fb[30 + i] = v.dst_ip[31 - 8*i -: 8];
    end
    fb[34] = v.icmp_type; fb[35] = 8'h00;
    fb[38] = REQ_ID[15:8]; fb[39] = REQ_ID[7:0];
    fb[40] = v.seq[15:8];  fb[41] = v.seq[7:0];
    for (int i = 0; i < 32; i++) fb[42 + i] = 8'(i);
  endtask

  // Drives beats first..last_beat; returns at #1 after the tlast beat's edge
  task automatic send_frame(input vec_t v, input int first, input int last);
    build(v);
    for (int b = first; b <= last; b++) begin
      for (int n = 0; n < 8; n++) rx_axis_tdata[8*n +: 8] = fb[8*b + n];
      rx_axis_tvalid  = 1'b1;
      rx_axis_tlast   = (b == v.last_beat);
      rx_axis_tkeep   = (b == v.last_beat) ? v.keep_last : 8'hff;
      rx_axis_tuser   = (b == v.last_beat) ? v.tuser : 1'b0;
      icmp_reply_done = (b == v.last_beat) && v.done_on_last;
      @(posedge aclk); #1;
      rx_axis_tvalid  = 1'b0;
      rx_axis_tlast   = 1'b0;
      icmp_reply_done = 1'b0;
      if (b != last) repeat (v.gap) begin @(posedge aclk); #1; end
    end
  endtask

  task automatic check_fields(input string nm);
    chk({nm, "_mac"},  256'(icmp_src_mac), 256'(m_mac));
    chk({nm, "_ip"},   256'(icmp_src_ip), 256'(m_ip));
    chk({nm, "_id"},   256'(icmp_src_identifier), 256'(m_id));
    chk({nm, "_seq"},  256'(icmp_src_sequence_number), 256'(m_seq));
    chk({nm, "_data"}, icmp_src_data, m_data);
  endtask

  // Pulse must appear in the cycle right after tlast and last exactly one cycle
  task automatic check_after(input vec_t v);
    chk({v.name, "_pulse"}, 256'(tx_icmp_en), 256'(v.exp_pulse));
    if (v.exp_pulse) begin
      m_mac = REQ_MAC; m_ip = REQ_IP; m_id = REQ_ID; m_seq = v.seq; m_data = payload;
      exp_pulses++;
    end
    check_fields(v.name);
    @(posedge aclk); #1;
    chk({v.name, "_pulse_end"}, 256'(tx_icmp_en), 256'(0));
    $display("frame %-12s seq=%h pulse_exp=%0b seq_out=%h", v.name, v.seq, v.exp_pulse,
             icmp_src_sequence_number);
  endtask

  task automatic pulse_done();
    icmp_reply_done = 1'b1;
    @(posedge aclk); #1;
    icmp_reply_done = 1'b0;
    @(posedge aclk); #1;
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < 32; i++) payload[255 - 8*i -: 8] = 8'(i);

    //          name            dst_ip    type   seq      tu  lb  keep   gap dol da ep
    vecs[0]  = mk("valid",      BOARD_IP, 8'd8, 16'h0007, 1, 9,  8'h03, 0, 0, 1, 1);
    vecs[1]  = mk("bad_dst_ip", IP_OTHER, 8'd8, 16'h0070, 1, 9,  8'h03, 0, 0, 0, 0);
    vecs[2]  = mk("type0",      BOARD_IP, 8'd0, 16'h0071, 1, 9,  8'h03, 0, 0, 0, 0);
    vecs[3]  = mk("tuser0",     BOARD_IP, 8'd8, 16'h0072, 0, 9,  8'h03, 0, 0, 0, 0);
    vecs[4]  = mk("valid2",     BOARD_IP, 8'd8, 16'h0007, 1, 9,  8'h03, 0, 0, 0, 1);
    vecs[5]  = mk("busy_drop",  BOARD_IP, 8'd8, 16'h0008, 1, 9,  8'h03, 0, 0, 1, 0);
    vecs[6]  = mk("after_done", BOARD_IP, 8'd8, 16'h0009, 1, 9,  8'h03, 0, 0, 0, 1);
    vecs[7]  = mk("done_tlast", BOARD_IP, 8'd8, 16'h000a, 1, 9,  8'h03, 0, 1, 0, 0);
    vecs[8]  = mk("post_done",  BOARD_IP, 8'd8, 16'h000b, 1, 9,  8'h03, 0, 0, 1, 1);
    vecs[9]  = mk("short",      BOARD_IP, 8'd8, 16'h0073, 1, 8,  8'hff, 0, 0, 0, 0);
    vecs[10] = mk("keep01",     BOARD_IP, 8'd8, 16'h0074, 1, 9,  8'h01, 0, 0, 0, 0);
    vecs[11] = mk("padded",     BOARD_IP, 8'd8, 16'h000c, 1, 10, 8'h0f, 0, 0, 1, 1);
    vecs[12] = mk("gapped",     BOARD_IP, 8'd8, 16'h0007, 1, 9,  8'h03, 3, 0, 1, 1);

    areset = 1'b1;
    rx_axis_tdata = '0; rx_axis_tkeep = '0; rx_axis_tvalid = 1'b0;
    rx_axis_tlast = 1'b0; rx_axis_tuser = 1'b0; icmp_reply_done = 1'b0;
    m_mac = '0; m_ip = '0; m_id = '0; m_seq = '0; m_data = '0;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(posedge aclk); #1;

    chk("reset_pulse", 256'(tx_icmp_en), 256'(0));
    check_fields("reset");

    // One-beat frame: rejected, and it also ends the post-reset resync
    v = mk("one_beat", BOARD_IP, 8'd8, 16'h0007, 1, 0, 8'hff, 0, 0, 0, 0);
    send_frame(v, 0, 0);
    check_after(v);

    for (int i = 0; i < 13; i++) begin
      send_frame(vecs[i], 0, vecs[i].last_beat);
      check_after(vecs[i]);
      if (vecs[i].done_after) pulse_done();
    end

    // Reset in the middle of a frame: outputs clear, tail is discarded
    v = mk("rst_head", BOARD_IP, 8'd8, 16'h0055, 1, 9, 8'h03, 0, 0, 0, 0);
    send_frame(v, 0, 4);
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    m_mac = '0; m_ip = '0; m_id = '0; m_seq = '0; m_data = '0;
    chk("midrst_pulse", 256'(tx_icmp_en), 256'(0));
    check_fields("midrst");
    v.name = "rst_tail";
    send_frame(v, 5, 9);
    check_after(v);
    v = mk("post_rst", BOARD_IP, 8'd8, 16'h0007, 1, 9, 8'h03, 0, 0, 1, 1);
    send_frame(v, 0, 9);
    check_after(v);
    pulse_done();

    repeat (3) @(posedge aclk);
    #1 chk("total_pulses", 256'(pulse_cnt), 256'(exp_pulses));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
